// File: rtl/ball_motion_pkg.sv
// Shared Pong definitions: screen and paddle geometry, ball FSM states,
// and the paddle vertical-overlap helper.
package pong_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL_SIZE   = 15;
  localparam int PADDLE_L_X  = 20;
  localparam int PADDLE_R_X  = 605;
  localparam int PADDLE_W    = 15;
  localparam int PADDLE_H    = 60;
  localparam int SPEED       = 2;
  localparam int HOLD_FRAMES = 60;

  // Ball home position (centre of the field).
  localparam logic [9:0] BALL_CX = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_CY = 10'((SCREEN_H - BALL_SIZE) / 2);

  // Horizontal landmarks, kept at 11 bits so the compares never wrap.
  localparam logic [10:0] X_L_EDGE = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] X_R_EDGE = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]  Y_MAX    = 10'(SCREEN_H - BALL_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_SCORED = 2'd2
  } ball_state_e;

  // True when the ball (top edge y) shares rows with a paddle (top edge py).
  function automatic logic paddle_overlap(input logic [9:0] y, input logic [9:0] py);
    logic [10:0] y11;
    logic [10:0] py11;
    y11  = {1'b0, y};
    py11 = {1'b0, py};
    return ((y11 + 11'(BALL_SIZE)) > py11) && (y11 < (py11 + 11'(PADDLE_H)));
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Ball controller bus: frame/serve controls and paddle positions in,
// ball position and event pulses out.
interface ball_motion_if;
  logic       frame_tick;
  logic       serve;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       hit;
  logic       point_l;
  logic       point_r;
  logic       in_play;

  // Game/video side that drives the controls and consumes the ball position.
  modport master (
    output frame_tick, serve, paddle_l_y, paddle_r_y,
    input  ball_x, ball_y, hit, point_l, point_r, in_play
  );

  // Ball motion controller.
  modport slave (
    input  frame_tick, serve, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, hit, point_l, point_r, in_play
  );
endinterface

// File: rtl/ball_motion_axis_step.sv
// One-axis ball step: advance by speed toward the current direction and
// clamp-and-reflect at 0 (low) and hi_i (high). Purely combinational.
module ball_axis_step (
  input  logic [9:0] pos_i,
  input  logic       dir_i,    // 1: increasing, 0: decreasing
  input  logic [3:0] speed_i,
  input  logic [9:0] hi_i,
  output logic [9:0] pos_o,
  output logic       dir_o
);

  logic [10:0] pos11;
  logic [10:0] sp11;
  logic [10:0] hi11;

  assign pos11 = {1'b0, pos_i};
  assign sp11  = {7'd0, speed_i};
  assign hi11  = {1'b0, hi_i};

  // Step with wall clamp and direction flip.
  always_comb begin
    pos_o = pos_i;
    dir_o = dir_i;
    if (dir_i) begin
      if ((pos11 + sp11) >= hi11) begin
        pos_o = hi_i;
        dir_o = 1'b0;
      end else begin
        pos_o = 10'(pos11 + sp11);
      end
    end else begin
      if (pos11 <= sp11) begin
        pos_o = 10'd0;
        dir_o = 1'b1;
      end else begin
        pos_o = 10'(pos11 - sp11);
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Frame-rate ball position controller with serve/score FSM.
// Optional feature: BALL_SPEEDUP_EN adds a speed register that grows by one
// per paddle hit (saturating at twice the base speed) and resets on IDLE.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   ST_IDLE   | ball parked at centre, waiting for serve
//   ST_MOVE   | ball advances one step per frame_tick
//   ST_SCORED | ball frozen for HOLD_FRAMES ticks after a point
module ball_motion
  import pong_pkg::*;
(
  input  logic          pixel_clk,
  input  logic          rst_n,
  ball_motion_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

  ball_state_e      state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             dx_q, dx_d;    // 1: right
  logic             dy_q, dy_d;    // 1: down
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             pl_q, pl_d;
  logic             pr_q, pr_d;
  logic [3:0]       spd;

`ifdef BALL_SPEEDUP_EN
  logic [3:0]       spd_q, spd_d;
  assign spd = spd_q;
`else
  assign spd = 4'(SPEED);
`endif

  logic [9:0]  y_step;
  logic        dy_step;
  logic [10:0] x11;
  logic [10:0] sp11;
  logic        ovl_l;
  logic        ovl_r;

  assign x11   = {1'b0, x_q};
  assign sp11  = {7'd0, spd};
  assign ovl_l = paddle_overlap(y_q, bus.paddle_l_y);
  assign ovl_r = paddle_overlap(y_q, bus.paddle_r_y);

  ball_axis_step u_y_step (
    .pos_i   (y_q),
    .dir_i   (dy_q),
    .speed_i (spd),
    .hi_i    (Y_MAX),
    .pos_o   (y_step),
    .dir_o   (dy_step)
  );

  // State, position and pulse registers.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= BALL_CX;
      y_q     <= BALL_CY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      pl_q    <= 1'b0;
      pr_q    <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      spd_q   <= 4'(SPEED);
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
`ifdef BALL_SPEEDUP_EN
      spd_q   <= spd_d;
`endif
    end
  end

  // Next-state: serve handling, per-frame step, paddle/point decisions, hold.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    pl_d    = 1'b0;
    pr_d    = 1'b0;
`ifdef BALL_SPEEDUP_EN
    spd_d   = spd_q;
`endif

    case (state_q)
      ST_IDLE: begin
        x_d = BALL_CX;
        y_d = BALL_CY;
`ifdef BALL_SPEEDUP_EN
        spd_d = 4'(SPEED);
`endif
        if (bus.serve) state_d = ST_MOVE;
      end

      ST_MOVE: begin
        if (bus.frame_tick) begin
          y_d  = y_step;
          dy_d = dy_step;
          if (!dx_q) begin
            // Paddle reflection wins over the point check.
            if ((x11 >= X_L_EDGE) && ((x11 - sp11) <= X_L_EDGE) && ovl_l) begin
              x_d   = 10'(X_L_EDGE);
              dx_d  = 1'b1;
              hit_d = 1'b1;
            end else if (x11 <= sp11) begin
              x_d     = 10'd0;
              pr_d    = 1'b1;
              dx_d    = 1'b0;   // left player lost: next serve heads left
              dy_d    = 1'b1;
              state_d = ST_SCORED;
            end else begin
              x_d = 10'(x11 - sp11);
            end
          end else begin
            if ((x11 <= X_R_EDGE) && ((x11 + sp11) >= X_R_EDGE) && ovl_r) begin
              x_d   = 10'(X_R_EDGE);
              dx_d  = 1'b0;
              hit_d = 1'b1;
            end else if ((x11 + sp11) >= X_MAX) begin
              x_d     = 10'(X_MAX);
              pl_d    = 1'b1;
              dx_d    = 1'b1;   // right player lost: next serve heads right
              dy_d    = 1'b1;
              state_d = ST_SCORED;
            end else begin
              x_d = 10'(x11 + sp11);
            end
          end
`ifdef BALL_SPEEDUP_EN
          if (hit_d && (spd_q < 4'(2 * SPEED))) spd_d = spd_q + 4'd1;
`endif
        end
      end

      ST_SCORED: begin
        if (bus.frame_tick) begin
          if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
            cnt_d   = '0;
            x_d     = BALL_CX;
            y_d     = BALL_CY;
            state_d = ST_IDLE;
`ifdef BALL_SPEEDUP_EN
            spd_d   = 4'(SPEED);
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ball_x  = x_q;
  assign bus.ball_y  = y_q;
  assign bus.hit     = hit_q;
  assign bus.point_l = pl_q;
  assign bus.point_r = pr_q;
  assign bus.in_play = (state_q == ST_MOVE);

endmodule
